// File: rtl/com_bus_pkg.sv
// Shared types and helpers for the common-bus transaction controller.
package com_bus_pkg;

  localparam int MAX_CACHES = 8;
  localparam int IDX_W      = 3;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SNOOP    = 3'd1,
    MEM_RD   = 3'd2,
    INV_WAIT = 3'd3,
    DONE     = 3'd4,
    ERR      = 3'd5
  } txn_state_t;

  typedef enum logic [1:0] {
    OP_RD  = 2'd0,
    OP_RDX = 2'd1,
    OP_INV = 2'd2
  } bus_op_t;

  function automatic logic isOneHot(input logic [MAX_CACHES-1:0] vec);
    return ($countones(vec) == 1);
  endfunction

  function automatic logic [IDX_W-1:0] oneHotToIdx(input logic [MAX_CACHES-1:0] vec);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_CACHES; i++) begin
      if (vec[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/inv_collector.sv
// Gathers Invalidation_done responses from every cache except the requester
// and reports when all of them have been seen.
module inv_collector #(
  parameter int NUM_CACHES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic                  i_track,
  input  logic                  i_enable,
  input  logic [NUM_CACHES-1:0] i_othersMask,
  input  logic [NUM_CACHES-1:0] i_invDone,
  output logic                  o_complete
);

  logic [NUM_CACHES-1:0] r_invSeen;
  logic [NUM_CACHES-1:0] w_merged;

  assign w_merged   = r_invSeen | (i_invDone & i_othersMask);
  assign o_complete = ((w_merged & i_othersMask) == i_othersMask);

  // Load on start (so stale bits never leak in), accumulate while active, clear otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_invSeen <= '0;
    end else if (i_start) begin
      r_invSeen <= i_track ? (i_invDone & i_othersMask) : '0;
    end else if (i_enable) begin
      r_invSeen <= w_merged;
    end else begin
      r_invSeen <= '0;
    end
  end

endmodule

// File: rtl/com_bus_txn_ctrl.sv
// Sequences one common-bus transaction: snoop window, supply/abort or memory
// read, invalidation collection, completion counting and hang detection.
module com_bus_txn_ctrl
  import com_bus_pkg::*;
#(
  parameter int NUM_CACHES  = 4,
  parameter int ADDR_W      = 32,
  parameter int SNOOP_WIN   = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_CACHES-1:0] Com_Bus_Gnt_proc,
  input  logic                  BusRd,
  input  logic                  BusRdX,
  input  logic                  Invalidate,
  input  logic [ADDR_W-1:0]     Address_Com,
  input  logic [NUM_CACHES-1:0] Shared_local,
  input  logic [NUM_CACHES-1:0] Data_in_Bus,
  input  logic [NUM_CACHES-1:0] Invalidation_done,
  input  logic                  Mem_data_rdy,
  output logic                  Shared,
  output logic                  Mem_oprn_abort,
  output logic                  Mem_rd_req,
  output logic [ADDR_W-1:0]     Mem_rd_addr,
  output logic                  All_Invalidation_done,
  output logic                  txn_busy,
  output logic                  txn_timeout,
  output logic                  proto_err,
  output logic [15:0]           txn_count
);

  localparam int SNP_W = $clog2(SNOOP_WIN + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

  txn_state_t            r_state;
  txn_state_t            w_nextState;
  bus_op_t               r_op;
  bus_op_t               w_startOp;
  logic [IDX_W-1:0]      r_reqId;
  logic [ADDR_W-1:0]     r_addr;
  logic [SNP_W-1:0]      r_snpCnt;
  logic [TMO_W-1:0]      r_tmoCnt;
  logic                  r_shared;
  logic                  r_abort;
  logic                  r_allInv;
  logic                  r_timeout;
  logic                  r_protoErr;
  logic [15:0]           r_txnCount;

  logic [MAX_CACHES-1:0] w_gntExt;
  logic [NUM_CACHES-1:0] w_reqMask;
  logic [NUM_CACHES-1:0] w_othersMask;
  logic                  w_gntOneHot;
  logic                  w_anyOp;
  logic                  w_multiOp;
  logic                  w_start;
  logic                  w_badGnt;
  logic                  w_reqGnt;
  logic                  w_active;
  logic                  w_track;
  logic                  w_supplier;
  logic                  w_sharedHit;
  logic                  w_tmoHit;
  logic                  w_invComplete;

  assign w_gntExt     = MAX_CACHES'(Com_Bus_Gnt_proc);
  assign w_gntOneHot  = isOneHot(w_gntExt);
  assign w_anyOp      = BusRd | BusRdX | Invalidate;
  assign w_multiOp    = (BusRd & BusRdX) | (BusRd & Invalidate) | (BusRdX & Invalidate);
  assign w_start      = (r_state == IDLE) && w_gntOneHot && w_anyOp;
  assign w_badGnt     = (r_state == IDLE) && !w_gntOneHot && w_anyOp;
  assign w_startOp    = BusRdX ? OP_RDX : (BusRd ? OP_RD : OP_INV);
  assign w_reqMask    = NUM_CACHES'(1) << r_reqId;
  assign w_reqGnt     = |(Com_Bus_Gnt_proc & w_reqMask);
  assign w_othersMask = (r_state == IDLE) ? ~Com_Bus_Gnt_proc : ~w_reqMask;
  assign w_active     = (r_state == SNOOP) || (r_state == MEM_RD) || (r_state == INV_WAIT);
  assign w_track      = w_start ? (w_startOp != OP_RD) : (r_op != OP_RD);
  assign w_supplier   = |(Data_in_Bus & w_othersMask);
  assign w_sharedHit  = |(Shared_local & w_othersMask);
  assign w_tmoHit     = w_active && (r_tmoCnt == TMO_W'(TIMEOUT_CYC - 1));

  inv_collector #(
    .NUM_CACHES (NUM_CACHES)
  ) u_inv_collector (
    .clk          (clk),
    .rst          (rst),
    .i_start      (w_start),
    .i_track      (w_track),
    .i_enable     (w_active && (r_op != OP_RD)),
    .i_othersMask (w_othersMask),
    .i_invDone    (Invalidation_done),
    .o_complete   (w_invComplete)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nextState;
  end

  // Next-state decode: losing the grant wins, then timeout, then normal progress.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (w_start) w_nextState = (w_startOp == OP_INV) ? INV_WAIT : SNOOP;
      end
      SNOOP: begin
        if (!w_reqGnt)                      w_nextState = IDLE;
        else if (w_tmoHit)                  w_nextState = ERR;
        else if (w_supplier)                w_nextState = (r_op == OP_RD) ? DONE : INV_WAIT;
        else if (r_snpCnt == SNP_W'(1))     w_nextState = MEM_RD;
      end
      MEM_RD: begin
        if (!w_reqGnt)                      w_nextState = IDLE;
        else if (w_tmoHit)                  w_nextState = ERR;
        else if (Mem_data_rdy)              w_nextState = (r_op == OP_RD) ? DONE : INV_WAIT;
      end
      INV_WAIT: begin
        if (!w_reqGnt)                      w_nextState = IDLE;
        else if (w_tmoHit)                  w_nextState = ERR;
        else if (w_invComplete)             w_nextState = DONE;
      end
      DONE, ERR: begin
        if (!w_reqGnt)                      w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Transaction datapath: latched request, counters and registered status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op       <= OP_RD;
      r_reqId    <= '0;
      r_addr     <= '0;
      r_snpCnt   <= '0;
      r_tmoCnt   <= '0;
      r_shared   <= 1'b0;
      r_abort    <= 1'b0;
      r_allInv   <= 1'b0;
      r_timeout  <= 1'b0;
      r_protoErr <= 1'b0;
      r_txnCount <= '0;
    end else begin
      if (w_start) begin
        r_op    <= w_startOp;
        r_reqId <= oneHotToIdx(w_gntExt);
        r_addr  <= Address_Com;
      end

      if (w_start)                 r_snpCnt <= SNP_W'(SNOOP_WIN);
      else if (r_state == SNOOP)   r_snpCnt <= r_snpCnt - SNP_W'(1);

      r_tmoCnt <= w_active ? (r_tmoCnt + TMO_W'(1)) : '0;

      if ((w_nextState == IDLE) || (w_nextState == ERR))  r_shared <= 1'b0;
      else if ((r_state == SNOOP) && w_sharedHit)         r_shared <= 1'b1;

      r_abort <= (r_state == SNOOP) && w_supplier &&
                 ((w_nextState == DONE) || (w_nextState == INV_WAIT));

      if ((w_nextState == IDLE) || (w_nextState == ERR)) begin
        r_allInv <= 1'b0;
      end else if (w_track && w_invComplete &&
                   ((w_nextState == INV_WAIT) ||
                    ((r_state == INV_WAIT) && (w_nextState == DONE)))) begin
        r_allInv <= 1'b1;
      end

      r_timeout <= w_tmoHit && (w_nextState == ERR);

      if (w_badGnt || (w_start && w_multiOp) || (w_active && !w_reqGnt)) r_protoErr <= 1'b1;

      if ((w_nextState == DONE) && (r_state != DONE)) r_txnCount <= r_txnCount + 16'd1;
    end
  end

  assign Shared                = r_shared;
  assign Mem_oprn_abort        = r_abort;
  assign Mem_rd_req            = (r_state == MEM_RD);
  assign Mem_rd_addr           = (r_state == MEM_RD) ? r_addr : '0;
  assign All_Invalidation_done = r_allInv;
  assign txn_busy              = (r_state != IDLE);
  assign txn_timeout           = r_timeout;
  assign proto_err             = r_protoErr;
  assign txn_count             = r_txnCount;

endmodule
